freq_div: RTL and testbench
===========================

FREQ_DIV -- requirements
Module: freq_div

Interface
REQ-001 The block SHALL have no parameters; the divide ratios 2, 3, 4 and 5 are fixed.
REQ-002 clk_in  input  1  sole clock; all flops run on clk_in (rising or falling edge).
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 clk_out_2x  output  1  clk_in divided by 2, 50% duty.
REQ-005 clk_out_3x  output  1  clk_in divided by 3, 50% duty.
REQ-006 clk_out_4x  output  1  clk_in divided by 4, 50% duty.
REQ-007 clk_out_5x  output  1  clk_in divided by 5, 50% duty.

Function
REQ-008 Edge numbering: "edge k" SHALL mean the k-th rising edge of clk_in after rst deasserts; "fall k" SHALL mean the falling edge between edge k and edge k+1.
REQ-009 clk_out_2x SHALL be a flop that toggles on every rising edge: high after edge 1, low after edge 2, period 2 clk_in cycles.
REQ-010 A 2-bit wrapping counter c4 (0,1,2,3,0...) SHALL advance on each rising edge; clk_out_4x SHALL toggle on rising edges where c4 (pre-edge) is 0 or 2: high after edge 1, low after edge 3, period 4.
REQ-011 A mod-3 counter c3 (0,1,2,0...) SHALL advance on each rising edge; rising-edge flop p3 SHALL be loaded with (c3 pre-edge == 0); falling-edge flop n3 SHALL sample p3; clk_out_3x = p3 OR n3.
REQ-012 clk_out_3x SHALL therefore be high from edge 1 to fall 2 (1.5 cycles) and low until edge 4 (1.5 cycles), period 3.
REQ-013 A mod-5 counter c5 (0..4) SHALL advance on each rising edge; rising-edge flop p5 SHALL be loaded with (c5 pre-edge == 0 or 1); falling-edge flop n5 SHALL sample p5; clk_out_5x = p5 OR n5.
REQ-014 clk_out_5x SHALL therefore be high from edge 1 to fall 3 (2.5 cycles) and low until edge 6 (2.5 cycles), period 5.
REQ-015 All four outputs SHALL rise together at edge 1 and realign (all rising) every 60 clk_in cycles.
REQ-016 The OR-combined odd outputs SHALL be glitch-free: p and n never change at the same clk_in edge.
REQ-017 Counters SHALL never hold out-of-range values (c3 never 3; c5 never 5-7); any illegal value SHALL wrap to 0 on the next rising edge.

Reset
REQ-018 While rst=0, all counters and all p/n flops SHALL be 0, and all four outputs SHALL be 0, immediately and without any clk_in edge.
REQ-019 Reset asserted mid-operation SHALL force all outputs low asynchronously, including in the middle of a high phase.
REQ-020 After rst deasserts, the sequence SHALL restart exactly as in REQ-009..REQ-014, counting from edge 1.
REQ-021 Reset release coincident with a rising edge: that edge SHALL NOT count as edge 1; the next rising edge SHALL be edge 1.

Verification
REQ-022 clk_in period 10 ns, rst low then released -> measured periods 20/30/40/50 ns, high times 10/15/20/25 ns.
REQ-023 Check at first rising edge after release -> all four outputs 0->1 at that edge; clk_out_3x falls 15 ns later; clk_out_5x falls 25 ns later.
REQ-024 Assert rst for 7 ns while clk_out_5x is high -> all outputs 0 within the reset window with no clock edge; after release all restart in phase per REQ-023.
REQ-025 Run 60+ clk_in cycles -> all outputs rise simultaneously at edge 1 and again at edge 61; no output pulse narrower than 10 ns (glitch check).
REQ-026 Hold rst low across 20 clk_in cycles -> all outputs remain 0 throughout.

Source files
------------

// File: rtl/freq_div_if.sv
`timescale 1ns/1ps
// Bundle of the four divided clock outputs of freq_div.
// Combinational fan-out only; no handshake or backpressure.
interface freq_div_if;
  logic clk_out_2x;
  logic clk_out_3x;
  logic clk_out_4x;
  logic clk_out_5x;

  modport master (output clk_out_2x, output clk_out_3x, output clk_out_4x, output clk_out_5x);
  modport slave  (input  clk_out_2x, input  clk_out_3x, input  clk_out_4x, input  clk_out_5x);
endinterface

// File: rtl/freq_div.sv
`timescale 1ns/1ps
// Fixed /2 /3 /4 /5 clock divider, 50% duty; all outputs rise together on the first edge after reset.
// Outputs change on the edge itself (no added latency); free-running, no backpressure.
module freq_div (
  input  logic       clk_in,
  input  logic       rst,
  freq_div_if.master div
);

  logic [1:0] c4;
  logic [1:0] c3;
  logic [2:0] c5;
  logic       p2;
  logic       p4;
  logic       p3;
  logic       n3;
  logic       p5;
  logic       n5;
  logic [1:0] c3_nxt;
  logic [2:0] c5_nxt;

  // Any out-of-range count (c3 = 3, c5 = 5..7) falls back to 0.
  always_comb begin
    c3_nxt = (c3 >= 2'd2) ? 2'd0 : c3 + 2'd1;
    c5_nxt = (c5 >= 3'd4) ? 3'd0 : c5 + 3'd1;
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      c4 <= 2'd0;
      c3 <= 2'd0;
      c5 <= 3'd0;
      p2 <= 1'b0;
      p4 <= 1'b0;
      p3 <= 1'b0;
      p5 <= 1'b0;
    end else begin
      c4 <= c4 + 2'd1;
      c3 <= c3_nxt;
      c5 <= c5_nxt;
      p2 <= ~p2;
      if (!c4[0]) begin
        p4 <= ~p4;
      end
      p3 <= (c3 == 2'd0);
      p5 <= (c5 < 3'd2);
    end
  end

  // Falling-edge copies stretch the odd-ratio high phase by half a cycle.
  always_ff @(negedge clk_in or negedge rst) begin
    if (!rst) begin
      n3 <= 1'b0;
      n5 <= 1'b0;
    end else begin
      n3 <= p3;
      n5 <= p5;
    end
  end

  assign div.clk_out_2x = p2;
  assign div.clk_out_4x = p4;
  assign div.clk_out_3x = p3 | n3;
  assign div.clk_out_5x = p5 | n5;

endmodule

// File: tb/tb_freq_div.sv
`timescale 1ns/1ps
// Scoreboard bench for freq_div: stimulus pushes the expected output vector for every clk_in half-cycle,
// a monitor samples 2 ns after each clk_in edge and compares; a second monitor flags pulses under 10 ns.
module tb_freq_div;

  bit clk_in;
  bit rst;
  freq_div_if div_if ();

  freq_div dut (
    .clk_in (clk_in),
    .rst    (rst),
    .div    (div_if.master)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_samp   = 0;

  logic [3:0] exp_q [$];

  // Model state: h counts half-cycles since edge 1 (h = 0 is the high half right after edge 1).
  int h       = 0;
  bit started = 0;

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  function automatic logic [3:0] outs();
    return {div_if.clk_out_5x, div_if.clk_out_4x, div_if.clk_out_3x, div_if.clk_out_2x};
  endfunction

  // Expected {5x,4x,3x,2x}: each output is high for the first half of its period.
  task automatic push_exp();
    logic [3:0] e;
    if (!started) e = 4'b0000;
    else          e = {(h % 10) < 5, (h % 8) < 4, (h % 6) < 3, (h % 4) < 2};
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(clk_in);
    if (clk_in) begin
      if (rst) begin
        if (started) h++;
        else begin
          started = 1;
          h = 0;
        end
      end
    end else if (started) begin
      h++;
    end
  endtask

  task automatic assert_rst();
    rst = 1'b0;
    started = 0;
  endtask

  // Sample monitor.
  initial begin
    logic [3:0] cur;
    logic [3:0] e;
    forever begin
      @(clk_in);
      #2;
      cur = outs();
      n_samp++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_underflow sample %0d: got %b, no expectation queued", n_samp, cur);
      end else begin
        e = exp_q.pop_front();
        if (cur === e) n_pass++;
        else $display("FAIL sb_sample %0d at %0t: outputs {5x,4x,3x,2x} got %b want %b", n_samp, $time, cur, e);
      end
    end
  end

  // Pulse-width monitor: any output change closer than 10 ns to the previous one (outside reset).
  initial begin
    logic [3:0] prev;
    logic [3:0] cur;
    realtime    last_t [4];
    bit         vld [4];
    prev = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      vld[i] = 0;
      last_t[i] = 0.0;
    end
    forever begin
      @(div_if.clk_out_2x or div_if.clk_out_3x or div_if.clk_out_4x or div_if.clk_out_5x or rst);
      cur = outs();
      if (!rst) begin
        for (int i = 0; i < 4; i++) vld[i] = 0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (cur[i] !== prev[i]) begin
            if (vld[i]) begin
              n_checks++;
              if ($realtime - last_t[i] < 10.0)
                $display("FAIL glitch out%0d at %0t: pulse %0.3f ns, need >= 10 ns", i, $time, $realtime - last_t[i]);
              else
                n_pass++;
            end
            vld[i] = 1;
            last_t[i] = $realtime;
          end
        end
      end
      prev = cur;
    end
  end

  // Stimulus.
  initial begin
    logic [3:0] cur;
    rst = 1'b0;
    #1;
    cur = outs();
    n_checks++;
    if (cur === 4'b0000) n_pass++;
    else $display("FAIL reset_t0: got %b want 0000", cur);

    // Reset held for 20 clk_in cycles.
    repeat (40) begin
      step();
      push_exp();
    end
    #3 rst = 1'b1;

    // Run through edge 61 and beyond, then land on a rising edge with 5x high.
    repeat (132) begin
      step();
      push_exp();
    end
    step();
    #1 assert_rst();
    push_exp();
    step();
    push_exp();
    #3 rst = 1'b1;

    // Restart after a 7 ns reset pulse, through realignment.
    repeat (130) begin
      step();
      push_exp();
    end

    // Reset again, released right on a rising edge: that edge must not count.
    step();
    #1 assert_rst();
    push_exp();
    repeat (3) begin
      step();
      push_exp();
    end
    step();
    push_exp();
    #0.001 rst = 1'b1;
    repeat (24) begin
      step();
      push_exp();
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL sb_drain: %0d expectations left, need 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
